byte_data_memory: RTL and testbench

BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

---
 rtl/byte_data_memory.sv | 154 +++++++++++++++
 tb/tb_byte_data_memory.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with a request/response port, load sign/zero
// extension, misalignment detection and a fixed-latency in-order response pipe.
// After reset the array is cleared one word per cycle before requests are accepted.
// Optional macro DMEM_STATS_EN adds saturating load/store/error counters.
module byte_data_memory #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic [15:0]       err_count
`endif
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NBYTES);
  localparam int unsigned IDX_W  = ADDR_W - LANE_W;
  localparam int unsigned DEPTH  = (1 << ADDR_W) / NBYTES;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   init_idx;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [LANE_W-1:0]  lane;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         size_mask;
  logic               req_err;
  logic               accept;
  logic [15:0]        be_wide;
  logic [NBYTES-1:0]  wbe;
  logic [DATA_W-1:0]  wdata_sh;
  logic [DATA_W-1:0]  rshift;
  logic [6:0]         nbits;
  logic [DATA_W-1:0]  lmask;
  logic [DATA_W-1:0]  ltop;
  logic               lsign;
  logic [DATA_W-1:0]  ldata;

  logic               pv [READ_LAT];
  logic               pe [READ_LAT];
  logic [DATA_W-1:0]  pd [READ_LAT];

  // Request decode: lane/index split, alignment check, store lanes, load extraction
  always_comb begin
    lane      = req_addr[LANE_W-1:0];
    idx       = req_addr[ADDR_W-1:LANE_W];
    size_mask = 3'((4'd1 << req_size) - 4'd1);
    req_err   = ((req_addr[2:0] & size_mask) != 3'd0) ||
                ((req_size == 2'd3) && (DATA_W == 32));
    accept    = req_valid && req_ready && !reset;
    be_wide   = (16'd1 << (5'd1 << req_size)) - 16'd1;
    wbe       = NBYTES'(be_wide << lane);
    wdata_sh  = req_wdata << {lane, 3'b000};
    rshift    = mem[idx] >> {lane, 3'b000};
    nbits     = 7'd8 << req_size;
    lmask     = (nbits >= 7'(DATA_W)) ? '1 : ((DATA_W'(1) << nbits) - DATA_W'(1));
    ltop      = lmask & ~(lmask >> 1);
    lsign     = !req_unsigned && ((rshift & ltop) != '0);
    ldata     = (rshift & lmask) | (lsign ? ~lmask : '0);
  end

  // Init/run sequencing: sweep every word once after reset, then accept requests
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      init_idx  <= '0;
      req_ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (init_idx == IDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
          end
        end
        RUN:     req_ready <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

  // Array write port: clearing sweep during INIT, byte-lane stores in RUN
  always_ff @(posedge clock) begin
    if (!reset && state == INIT) begin
      mem[init_idx] <= '0;
    end else if (accept && req_write && !req_err) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wbe[b]) mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  // Response pipe: captured at acceptance, shifted so it emerges READ_LAT cycles later
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && req_err;
      pd[0] <= (accept && !req_write && !req_err) ? ldata : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign rsp_valid = pv[READ_LAT-1];
  assign rsp_error = pe[READ_LAT-1];
  assign rsp_rdata = pd[READ_LAT-1];

`ifdef DMEM_STATS_EN
  // Saturating counters of accepted legal loads, legal stores and errored requests
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (req_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (req_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_byte_data_memory.sv
// Randomised bench for byte_data_memory (DATA_W=32, ADDR_W=7, READ_LAT=3) with a
// byte-array reference model; optional counter checks when DMEM_STATS_EN is defined.
module tb_byte_data_memory;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 7;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
`ifdef DMEM_STATS_EN
  logic [15:0]   rd_count, wr_count, err_count;
`endif

  byte_data_memory #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
`ifdef DMEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { int due; logic err; logic [31:0] data; } exp_t;
  typedef struct { int cyc; logic err; logic [31:0] data; } got_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   since = 0;
  bit   started = 1'b0;
  int   last_drive_cyc = 0;
  exp_t q[$];
  got_t got_q[$];
  logic [7:0] mm [128];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: little-endian byte array, alignment rule, sign/zero extension
  function automatic void model_req(input logic wr, input logic [1:0] sz, input logic uns,
                                    input logic [6:0] a, input logic [31:0] wd,
                                    output logic err, output logic [31:0] rd);
    int n;
    logic [63:0] v;
    n   = 1 << sz;
    err = (sz == 2'd3 && DW == 32) || ((int'(a) % n) != 0);
    rd  = '0;
    v   = '0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[int'(a) + i];
        if (!uns && v[8*n-1]) v = v | (~64'd0 << (8*n));
        rd = v[31:0];
      end
    end
  endfunction

  // Per-cycle compare against the model; also logs every DUT response
  always @(posedge clock) begin
    logic r;
    exp_t e;
    got_t g;
    r = reset;
    cyc++;
    if (r) begin since = 0; started = 1'b1; end
    else since++;
    #1;
    if (started) begin
      if (r) begin
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_error", 64'(rsp_error), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
      end else begin
        chk("ready", 64'(req_ready), 64'(since >= DEPTH));
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'd1);
          chk("rsp_error", 64'(rsp_error), 64'(e.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
        end else begin
          chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        end
      end
      if (rsp_valid === 1'b1) begin
        g.cyc = cyc; g.err = rsp_error; g.data = rsp_rdata;
        got_q.push_back(g);
      end
    end
  end

  int m_rd = 0, m_wr = 0, m_err = 0;

  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [6:0] a, input logic [31:0] wd);
    logic e;
    logic [31:0] d;
    exp_t x;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    last_drive_cyc = cyc;
    if (since >= DEPTH && !reset) begin
      model_req(wr, sz, uns, a, wd, e, d);
      x.due = cyc + LAT; x.err = e; x.data = d;
      q.push_back(x);
      if (e) m_err++; else if (wr) m_wr++; else m_rd++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      req_valid = 1'b0;
      req_wdata = $urandom;
      req_addr  = 7'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    req_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 128; i++) mm[i] = 8'h00;
    m_rd = 0; m_wr = 0; m_err = 0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic count_init(input string name);
    int n;
    for (n = 1; n <= 100; n++) begin
      @(posedge clock); #1;
      if (req_ready === 1'b1) break;
    end
    chk(name, 64'(n), 64'(DEPTH));
  endtask

  task automatic wait_got(input int k);
    int t;
    for (t = 0; t < 20 && got_q.size() < k; t++) @(negedge clock);
    if (got_q.size() < k) chk("rsp_timeout", 64'(got_q.size()), 64'(k));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [6:0] a;
    logic [1:0] sz;

    // Reset release: ready low for exactly DEPTH cycles, top word reads zero
    do_reset(3);
    count_init("init_cycles");
    got_q.delete();
    drive(1'b0, 2'd2, 1'b0, 7'h7C, 32'h0);
    idle(1); wait_got(1);
    chk("load_7c", 64'(got_q[0].data), 64'h0);
    chk("load_7c_err", 64'(got_q[0].err), 64'd0);

    // Byte store then signed/unsigned byte loads and a word load
    got_q.delete();
    drive(1'b1, 2'd0, 1'b0, 7'h05, 32'h80);
    drive(1'b0, 2'd0, 1'b0, 7'h05, 32'h0);
    drive(1'b0, 2'd0, 1'b1, 7'h05, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 7'h04, 32'h0);
    idle(1); wait_got(4);
    chk("store_rsp_data", 64'(got_q[0].data), 64'h0);
    chk("lb_signed", 64'(got_q[1].data), 64'hFFFFFF80);
    chk("lb_unsigned", 64'(got_q[2].data), 64'h00000080);
    chk("lw_04", 64'(got_q[3].data), 64'h00008000);

    // Misaligned half store is rejected and leaves memory intact
    got_q.delete();
    drive(1'b1, 2'd2, 1'b0, 7'h00, 32'h11223344);
    drive(1'b1, 2'd1, 1'b0, 7'h03, 32'hABCD);
    drive(1'b0, 2'd2, 1'b0, 7'h00, 32'h0);
    idle(1); wait_got(3);
    chk("mis_err", 64'(got_q[1].err), 64'd1);
    chk("mis_data", 64'(got_q[1].data), 64'h0);
    chk("after_mis", 64'(got_q[2].data), 64'h11223344);

    // Back-to-back store/load, responses at +3 and +4
    got_q.delete();
    drive(1'b1, 2'd2, 1'b0, 7'h10, 32'hDEADBEEF);
    t0 = last_drive_cyc;
    drive(1'b0, 2'd2, 1'b0, 7'h10, 32'h0);
    idle(1); wait_got(2);
    chk("b2b_st_cyc", 64'(got_q[0].cyc - t0), 64'd3);
    chk("b2b_ld_cyc", 64'(got_q[1].cyc - t0), 64'd4);
    chk("b2b_ld_data", 64'(got_q[1].data), 64'hDEADBEEF);

    // Reset with two loads in flight: both dropped, memory re-cleared
    drive(1'b1, 2'd2, 1'b0, 7'h20, 32'h12345678);
    idle(1);
    drive(1'b0, 2'd2, 1'b0, 7'h20, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 7'h20, 32'h0);
    got_q.delete();
    do_reset(2);
    count_init("reinit_cycles");
    chk("flush_no_rsp", 64'(got_q.size()), 64'd0);
    drive(1'b0, 2'd2, 1'b0, 7'h20, 32'h0);
    idle(1); wait_got(1);
    chk("after_rst_data", 64'(got_q[0].data), 64'h0);

    // Reset asserted part-way through the clear sweep restarts it
    do_reset(1);
    idle(10);
    do_reset(1);
    count_init("mid_init_cycles");

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        sz = 2'($urandom_range(0, 3));
        a  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) a = a & ~7'((1 << sz) - 1);
        drive(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    idle(LAT + 2);
    chk("drain", 64'(q.size()), 64'd0);

`ifdef DMEM_STATS_EN
    // Counters: 3 loads, 2 stores, 1 misaligned
    do_reset(2);
    count_init("stats_init_cycles");
    drive(1'b0, 2'd2, 1'b0, 7'h00, 32'h0);
    drive(1'b1, 2'd1, 1'b0, 7'h02, 32'h5555);
    drive(1'b0, 2'd0, 1'b1, 7'h03, 32'h0);
    drive(1'b1, 2'd2, 1'b0, 7'h06, 32'h1);
    drive(1'b1, 2'd0, 1'b0, 7'h09, 32'h7);
    drive(1'b0, 2'd1, 1'b0, 7'h0A, 32'h0);
    idle(LAT + 2);
    chk("rd_count", 64'(rd_count), 64'd3);
    chk("wr_count", 64'(wr_count), 64'd2);
    chk("err_count", 64'(err_count), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
